// File: rtl/fsqrt_seq.sv
// fsqrt_seq: multi-cycle IEEE-754 square root (binary32/binary64), radix-2 restoring recurrence, RNE.
// Define FSQRT_SEQ_FLAGS_EN to add a {invalid, inexact} flags output.
module fsqrt_seq #(
  parameter int BUS_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BUS_WIDTH-1:0] in1,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [BUS_WIDTH-1:0] out,
  output logic                 out_valid,
  input  logic                 out_ready
`ifdef FSQRT_SEQ_FLAGS_EN
  ,
  output logic [1:0]           flags
`endif
);
  localparam int MANT = (BUS_WIDTH == 64) ? 52 : 23;
  localparam int EXP  = (BUS_WIDTH == 64) ? 11 : 8;
  localparam int BIAS = (BUS_WIDTH == 64) ? 1023 : 127;
  localparam int ITER = MANT + 2;
  localparam int RW   = 2 * ITER;
  localparam int CW   = $clog2(ITER);

  localparam logic [1:0] S_IDLE = 2'd0, S_CALC = 2'd1, S_ROUND = 2'd2, S_DONE = 2'd3;

  localparam logic [BUS_WIDTH-1:0] QNAN = {1'b0, {EXP{1'b1}}, 1'b1, {(MANT-1){1'b0}}};
  localparam logic [BUS_WIDTH-1:0] PINF = {1'b0, {EXP{1'b1}}, {MANT{1'b0}}};

  logic [1:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [RW-1:0]        rad_q, rad_d;
  logic [ITER:0]        rem_q, rem_d;
  logic [ITER-1:0]      root_q, root_d;
  logic [EXP-1:0]       exp_q, exp_d;
  logic [BUS_WIDTH-1:0] out_q, out_d;

  logic            sgn, is_nan, exp_ones;
  logic [EXP-1:0]  ex;
  logic [MANT-1:0] fr;
  assign sgn      = in1[BUS_WIDTH-1];
  assign ex       = in1[BUS_WIDTH-2:MANT];
  assign fr       = in1[MANT-1:0];
  assign exp_ones = &ex;
  assign is_nan   = exp_ones && (fr != '0);

  // floor((exp-BIAS)/2)+BIAS == floor((exp+BIAS)/2) for odd BIAS; LSB of the sum flags odd e.
  logic [EXP:0]    exp_sum;
  logic [ITER-1:0] m_init;
  assign exp_sum = {1'b0, ex} + (EXP+1)'(BIAS);
  assign m_init  = exp_sum[0] ? {1'b1, fr, 1'b0} : {2'b01, fr};

  logic [ITER+3:0] trial;
  logic [ITER+2:0] shifted;
  logic            ge;
  assign shifted = {rem_q, rad_q[RW-1 -: 2]};
  assign trial   = {1'b0, shifted} - {2'b00, root_q, 2'b01};
  assign ge      = ~trial[ITER+3];

  // Upper bits of the recurrence words are provably zero whenever they are kept.
  logic unused_ok;
  assign unused_ok = ^{trial[ITER+2:ITER+1], shifted[ITER+2:ITER+1]};

  logic            guard, sticky, rnd_up;
  logic [MANT+1:0] mant_rnd;
  assign guard    = root_q[0];
  assign sticky   = |rem_q;
  assign rnd_up   = guard & (sticky | root_q[1]);
  assign mant_rnd = {1'b0, root_q[ITER-1:1]} + {{(MANT+1){1'b0}}, rnd_up};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rad_d   = rad_q;
    rem_d   = rem_q;
    root_d  = root_q;
    exp_d   = exp_q;
    out_d   = out_q;
    case (state_q)
      S_IDLE: if (in_valid) begin
        state_d = S_DONE;
        if (is_nan)          out_d = QNAN;
        else if (ex == '0)   out_d = {sgn, {(BUS_WIDTH-1){1'b0}}};
        else if (sgn)        out_d = QNAN;
        else if (exp_ones)   out_d = PINF;
        else begin
          state_d = S_CALC;
          cnt_d   = '0;
          rad_d   = {m_init, {ITER{1'b0}}};
          rem_d   = '0;
          root_d  = '0;
          exp_d   = exp_sum[EXP:1];
        end
      end
      S_CALC: begin
        rad_d  = rad_q << 2;
        rem_d  = ge ? trial[ITER:0] : shifted[ITER:0];
        root_d = {root_q[ITER-2:0], ge};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(ITER-1)) state_d = S_ROUND;
      end
      S_ROUND: begin
        out_d   = {1'b0, exp_q + {{(EXP-1){1'b0}}, mant_rnd[MANT+1]}, mant_rnd[MANT-1:0]};
        state_d = S_DONE;
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rad_q   <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      exp_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rad_q   <= rad_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      exp_q   <= exp_d;
      out_q   <= out_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out       = out_q;

`ifdef FSQRT_SEQ_FLAGS_EN
  logic [1:0] flags_q;
  logic       spec_inv;
  // Signalling NaN (quiet bit clear) or any negative nonzero operand is invalid.
  assign spec_inv = is_nan ? ~fr[MANT-1] : (sgn && (ex != '0));
  always_ff @(posedge clk) begin
    if (rst)                                flags_q <= '0;
    else if (state_q == S_IDLE && in_valid) flags_q <= {spec_inv, 1'b0};
    else if (state_q == S_ROUND)            flags_q <= {1'b0, guard | sticky};
  end
  assign flags = flags_q;
`endif
endmodule

// File: tb/tb_fsqrt_seq.sv
// Self-checking bench for fsqrt_seq: binary32 and binary64 instances against an exact integer-sqrt model.
module tb_fsqrt_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in1_32 = '0, o32;
  logic [63:0] in1_64 = '0, o64;
  logic        iv32 = 1'b0, iv64 = 1'b0, ir32, ir64, ov32, ov64;
  logic        ordy32 = 1'b1, ordy64 = 1'b1;
`ifdef FSQRT_SEQ_FLAGS_EN
  logic [1:0]  fl32, fl64;
`endif
  int n_cmp = 0, n_err = 0, cyc = 0, last_hs = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fsqrt_seq #(.BUS_WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .in1(in1_32), .in_valid(iv32), .in_ready(ir32),
    .out(o32), .out_valid(ov32), .out_ready(ordy32)
`ifdef FSQRT_SEQ_FLAGS_EN
    , .flags(fl32)
`endif
  );
  fsqrt_seq #(.BUS_WIDTH(64)) u64 (
    .clk(clk), .rst(rst), .in1(in1_64), .in_valid(iv64), .in_ready(ir64),
    .out(o64), .out_valid(ov64), .out_ready(ordy64)
`ifdef FSQRT_SEQ_FLAGS_EN
    , .flags(fl64)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: exact floor-sqrt by binary search on the scaled radicand, then RNE.
  function automatic logic [63:0] ref_sqrt(input bit w64, input logic [63:0] x);
    int mant = w64 ? 52 : 23;
    int ew   = w64 ? 11 : 8;
    int bias = w64 ? 1023 : 127;
    logic [127:0] one = 128'd1;
    logic [63:0] fr, ex, qnan, inf;
    logic        sgn;
    logic [127:0] m, r, lo, hi, mid, rem, q, mn;
    int e, rexp;
    fr   = x & 64'((one << mant) - 1);
    ex   = (x >> mant) & 64'((one << ew) - 1);
    sgn  = w64 ? x[63] : x[31];
    qnan = w64 ? 64'h7ff8000000000000 : 64'h7fc00000;
    inf  = w64 ? 64'h7ff0000000000000 : 64'h7f800000;
    if (ex == 64'((one << ew) - 1) && fr != 0) return qnan;
    if (ex == 0) return sgn ? 64'(one << (w64 ? 63 : 31)) : 64'd0;
    if (sgn) return qnan;
    if (ex == 64'((one << ew) - 1)) return inf;
    e = int'(ex) - bias;
    m = (one << mant) | 128'(fr);
    if ((e % 2) != 0) begin m = m << 1; e = e - 1; end
    rexp = e / 2 + bias;
    r  = m << (mant + 2);
    lo = 0;
    hi = one << (mant + 2);
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= r) lo = mid; else hi = mid;
    end
    q   = lo;
    rem = r - q * q;
    mn  = q >> 1;
    if (q[0] && (rem != 0 || mn[0])) mn = mn + 1;
    if ((mn >> (mant + 1)) != 0) begin rexp++; mn = mn >> 1; end
    return (64'(rexp) << mant) | 64'(mn & ((one << mant) - 1));
  endfunction

  task automatic run_op(input bit w64, input logic [63:0] x, output logic [63:0] res, output int lat);
    @(negedge clk);
    chk(w64 ? "in_ready64" : "in_ready32", w64 ? 64'(ir64) : 64'(ir32), 64'd1);
    if (w64) begin in1_64 = x; iv64 = 1'b1; end
    else     begin in1_32 = x[31:0]; iv32 = 1'b1; end
    @(negedge clk);
    last_hs = cyc;
    iv32 = 1'b0; iv64 = 1'b0;
    in1_32 = $urandom; in1_64 = {$urandom, $urandom};
    lat = 1;
    while (!(w64 ? ov64 : ov32) && lat < 200) begin @(negedge clk); lat++; end
    res = w64 ? o64 : {32'd0, o32};
  endtask

  task automatic check_op(input bit w64, input logic [63:0] x, input logic [63:0] expv, input int explat);
    logic [63:0] res;
    int lat;
    run_op(w64, x, res, lat);
    chk($sformatf("res%0d_%h", w64 ? 64 : 32, x), res, expv);
    chk($sformatf("lat%0d_%h", w64 ? 64 : 32, x), 64'(lat), 64'(explat));
  endtask

  initial begin
    logic [63:0] x, held, res;
    int lat, hs0, hs1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out32", {32'd0, o32}, 64'd0);
    chk("rst_ov32", 64'(ov32), 64'd0);
    chk("rst_ir32", 64'(ir32), 64'd1);
    chk("rst_ov64", 64'(ov64), 64'd0);
    rst = 1'b0;

    check_op(0, 64'h40800000, 64'h40000000, 27);
`ifdef FSQRT_SEQ_FLAGS_EN
    chk("inexact_4p0", 64'(fl32[0]), 64'd0);
`endif
    check_op(0, 64'h40000000, 64'h3fb504f3, 27);
`ifdef FSQRT_SEQ_FLAGS_EN
    chk("inexact_2p0", 64'(fl32[0]), 64'd1);
`endif
    check_op(0, 64'hbf800000, 64'h7fc00000, 1);
`ifdef FSQRT_SEQ_FLAGS_EN
    chk("invalid_neg", 64'(fl32[1]), 64'd1);
`endif
    check_op(0, 64'h80000000, 64'h80000000, 1);
    check_op(0, 64'h7f800000, 64'h7f800000, 1);
    check_op(0, 64'h00000001, 64'h00000000, 1);
    check_op(0, 64'hff800000, 64'h7fc00000, 1);
    check_op(0, 64'h7f800001, 64'h7fc00000, 1);
    check_op(1, 64'h4022000000000000, 64'h4008000000000000, 56);
    check_op(1, 64'h3fe0000000000000, 64'h3fe6a09e667f3bcd, 56);
    check_op(1, 64'h8000000000000001, 64'h8000000000000000, 1);

    // Backpressure: result must hold and a second request must wait.
    ordy32 = 1'b0;
    run_op(0, 64'h40800000, held, lat);
    chk("bp_first", held, 64'h40000000);
    iv32 = 1'b1; in1_32 = 32'h3f800000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold_out", {32'd0, o32}, held);
      chk("bp_hold_ov", 64'(ov32), 64'd1);
      chk("bp_hold_ir", 64'(ir32), 64'd0);
    end
    ordy32 = 1'b1;
    @(negedge clk);
    chk("bp_consumed_ov", 64'(ov32), 64'd0);
    chk("bp_idle_ir", 64'(ir32), 64'd1);
    @(negedge clk);
    chk("bp_accept_ir", 64'(ir32), 64'd0);
    iv32 = 1'b0;
    lat = 0;
    while (!ov32 && lat < 200) begin @(negedge clk); lat++; end
    chk("bp_second_res", {32'd0, o32}, 64'h3f800000);

    // Reset during CALC discards the operation.
    run_op(0, 64'h3f800000, res, lat);
    @(negedge clk);
    iv32 = 1'b1; in1_32 = 32'h40000000;
    @(negedge clk);
    iv32 = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_ov", 64'(ov32), 64'd0);
    chk("midrst_ir", 64'(ir32), 64'd1);
    chk("midrst_out", {32'd0, o32}, 64'd0);
    check_op(0, 64'h3f800000, 64'h3f800000, 27);

    for (int i = 0; i < 30; i++) begin
      x = {32'd0, 1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
      check_op(0, x, ref_sqrt(0, x), 27);
    end
    for (int i = 0; i < 10; i++) begin
      x = {32'd0, $urandom};
      run_op(0, x, res, lat);
      chk($sformatf("any32_%h", x), res, ref_sqrt(0, x));
    end
    for (int i = 0; i < 15; i++) begin
      x = {1'b0, 11'($urandom_range(1, 2046)), 20'($urandom), $urandom};
      check_op(1, x, ref_sqrt(1, x), 56);
    end

    // Back-to-back throughput with out_ready held high.
    run_op(0, 64'h41100000, res, lat);
    hs0 = last_hs;
    chk("tp_res0", res, 64'h40400000);
    run_op(0, 64'h41c80000, res, lat);
    hs1 = last_hs;
    chk("tp_res1", res, 64'h40a00000);
    chk("tp_period", 64'(hs1 - hs0), 64'd28);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
